// File: rtl/dmem_responder.sv
// dmem_responder: data-memory model plus a pass/fail/timeout status monitor
// for a processor test harness. Loads are combinational. A store to the
// mailbox word ends the program as PASS or FAIL. Optional watchdog: define
// DMEM_WATCHDOG_EN to move the status to TIMEOUT after TIMEOUT_CYCLES
// cycles in RUN.
module dmem_responder #(
  parameter int DEPTH          = 64,
  parameter int PASS_ADR       = 100,
  parameter int PASS_VAL       = 7,
  parameter int TIMEOUT_CYCLES = 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [7:0]  wr_count
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] MEM_BYTES = 32'(4 * DEPTH);
  localparam logic [31:0] MAIL_ADR  = 32'(PASS_ADR);
  localparam logic [31:0] MAIL_VAL  = 32'(PASS_VAL);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_PASS,
    ST_FAIL,
    ST_TIMEOUT
  } state_t;

  state_t state, state_next;
  logic   done_next, pass_next, timeout_next;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] word_idx;
  logic          in_range;
  logic          store_ok;
  logic          mailbox_hit;
  logic          bad_store;
  logic          wd_expire;

  assign word_idx    = DataAdr[AW+1:2];
  assign in_range    = (DataAdr < MEM_BYTES) && (DataAdr[1:0] == 2'b00);
  // Stores are blocked while reset is held, so a core running during reset
  // cannot corrupt the preserved memory image.
  assign store_ok    = reset && MemWrite && in_range;
  assign mailbox_hit = MemWrite && (DataAdr == MAIL_ADR);
  assign bad_store   = MemWrite && !in_range;

  // Memory array: write port only, deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (store_ok) mem[word_idx] <= WriteData;
  end

  // Zero-latency load path; out-of-range or misaligned addresses read zero.
  always_comb begin
    ReadData = '0;
    if (in_range) ReadData = mem[word_idx];
  end

`ifdef DMEM_WATCHDOG_EN
  localparam int            WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt;

  // Watchdog: counts edges spent in RUN; freezes once status is terminal.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wd_cnt <= '0;
    else if (state == ST_RUN) wd_cnt <= wd_cnt + 1'b1;
  end

  // Expiry fires on the edge that would bring the count to TIMEOUT_CYCLES.
  assign wd_expire = (state == ST_RUN) && (wd_cnt == WD_LAST);
`else
  assign wd_expire = 1'b0;
`endif

  // Status next-state: a mailbox store outranks a bad store and watchdog expiry.
  always_comb begin
    state_next   = state;
    done_next    = 1'b0;
    pass_next    = 1'b0;
    timeout_next = 1'b0;
    if (state == ST_RUN) begin
      if (mailbox_hit) state_next = (WriteData == MAIL_VAL) ? ST_PASS : ST_FAIL;
      else if (bad_store) state_next = ST_FAIL;
      else if (wd_expire) state_next = ST_TIMEOUT;
    end
    case (state_next)
      ST_PASS:    begin done_next = 1'b1; pass_next    = 1'b1; end
      ST_FAIL:    begin done_next = 1'b1;                      end
      ST_TIMEOUT: begin done_next = 1'b1; timeout_next = 1'b1; end
      default:    ;
    endcase
  end

  // Status register and registered status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_RUN;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= done_next;
      pass  <= pass_next;
    end
  end

`ifdef DMEM_WATCHDOG_EN
  // Timeout flag register, present only with the watchdog.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) timeout <= 1'b0;
    else        timeout <= timeout_next;
  end
`else
  logic unused_timeout;
  assign unused_timeout = timeout_next;
  assign timeout        = 1'b0;
`endif

  // Accepted-store counter, saturating at 255, independent of status.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wr_count <= 8'd0;
    else if (store_ok && (wr_count != 8'hFF)) wr_count <= wr_count + 8'd1;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed bench for dmem_responder with a
// behavioural model of memory contents, status and store count.
module tb_dmem_responder;

  localparam int DEPTH    = 64;
  localparam int PASS_ADR = 100;
  localparam int PASS_VAL = 7;
  localparam int TMO      = 50;
`ifdef DMEM_WATCHDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  // Model status values
  localparam int M_RUN = 0, M_PASS = 1, M_FAIL = 2, M_TMO = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAdr = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic        done, pass, timeout;
  logic [7:0]  wr_count;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] m_mem [DEPTH];
  bit          m_val [DEPTH];
  int          m_st, m_cnt, m_cyc;

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH(DEPTH), .PASS_ADR(PASS_ADR), .PASS_VAL(PASS_VAL), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .ReadData(ReadData), .done(done), .pass(pass),
    .timeout(timeout), .wr_count(wr_count)
  );

  function automatic logic [10:0] exp_flags();
    return {m_st != M_RUN, m_st == M_PASS, m_st == M_TMO, 8'(m_cnt)};
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a, output bit known);
    int idx;
    known = 1'b1;
    if (a >= 32'(4 * DEPTH) || a[1:0] != 2'b00) return 32'h0;
    idx   = int'(a >> 2);
    known = m_val[idx];
    return m_mem[idx];
  endfunction

  // One rising edge as seen by the model (reset is high whenever it is called).
  task automatic model_edge(input logic we, input logic [31:0] adr, input logic [31:0] wd);
    bit inr;
    inr = (adr < 32'(4 * DEPTH)) && (adr[1:0] == 2'b00);
    if (we && inr) begin
      m_mem[adr >> 2] = wd;
      m_val[adr >> 2] = 1'b1;
      if (m_cnt < 255) m_cnt++;
    end
    if (m_st == M_RUN) begin
      if (we && adr == 32'(PASS_ADR)) m_st = (wd == 32'(PASS_VAL)) ? M_PASS : M_FAIL;
      else if (we && !inr) m_st = M_FAIL;
      else if (WD_ON && (m_cyc + 1 == TMO)) m_st = M_TMO;
      m_cyc++;
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] adr, input logic [31:0] wd);
    @(negedge clk);
    MemWrite  = we;
    DataAdr   = adr;
    WriteData = wd;
    @(posedge clk);
    model_edge(we, adr, wd);
    #1;
    MemWrite = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b0;
    MemWrite = 1'b0;
    m_st = M_RUN; m_cnt = 0; m_cyc = 0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [31:0] rand_word_adr();
    int w;
    w = $urandom_range(0, DEPTH - 1);
    if (w * 4 == PASS_ADR) w = 0;
    return 32'(w * 4);
  endfunction

  task automatic test_reset();
    bit k;
    reset = 1'b0;
    m_st = M_RUN; m_cnt = 0; m_cyc = 0;
    DataAdr = 32'd256;
    #3;
    n_checks++;
    if ({done, pass, timeout, wr_count} !== 11'h0)
      $display("FAIL reset_flags got=%h exp=%h", {done, pass, timeout, wr_count}, 11'h0);
    else n_pass++;
    n_checks++;
    if (ReadData !== exp_read(32'd256, k))
      $display("FAIL reset_read256 got=%h exp=0", ReadData);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 32'd0, 32'd0);
    n_checks++;
    if ({done, pass, timeout, wr_count} !== exp_flags())
      $display("FAIL reset_idle got=%h exp=%h", {done, pass, timeout, wr_count}, exp_flags());
    else n_pass++;
  endtask

  task automatic test_pass();
    bit k;
    do_reset();
    drive(1'b1, 32'd96, 32'd5);
    n_checks++;
    if ({done, pass, timeout, wr_count} !== exp_flags())
      $display("FAIL pass_first_store got=%h exp=%h", {done, pass, timeout, wr_count}, exp_flags());
    else n_pass++;
    drive(1'b1, 32'd100, 32'd7);
    n_checks++;
    if ({done, pass, timeout, wr_count} !== {1'b1, 1'b1, 1'b0, 8'd2})
      $display("FAIL pass_status got=%h exp=%h", {done, pass, timeout, wr_count}, {1'b1, 1'b1, 1'b0, 8'd2});
    else n_pass++;
    DataAdr = 32'd96;
    #1;
    n_checks++;
    if (ReadData !== exp_read(32'd96, k))
      $display("FAIL pass_read96 got=%h exp=%h", ReadData, exp_read(32'd96, k));
    else n_pass++;
  endtask

  task automatic test_fail_value();
    do_reset();
    drive(1'b1, 32'd100, 32'd8);
    n_checks++;
    if ({done, pass, timeout, wr_count} !== {1'b1, 1'b0, 1'b0, 8'd1})
      $display("FAIL failval_status got=%h exp=%h", {done, pass, timeout, wr_count}, {1'b1, 1'b0, 1'b0, 8'd1});
    else n_pass++;
    drive(1'b1, 32'd100, 32'd7);
    n_checks++;
    if ({done, pass, timeout, wr_count} !== exp_flags())
      $display("FAIL failval_absorb got=%h exp=%h", {done, pass, timeout, wr_count}, exp_flags());
    else n_pass++;
  endtask

  task automatic test_out_of_range();
    bit k;
    logic [31:0] e;
    do_reset();
    drive(1'b1, 32'd0, 32'hA5A5_0001);
    do_reset();
    drive(1'b1, 32'd256, 32'hDEAD_BEEF);
    n_checks++;
    if ({done, pass, timeout, wr_count} !== {1'b1, 1'b0, 1'b0, 8'd0})
      $display("FAIL oor_status got=%h exp=%h", {done, pass, timeout, wr_count}, {1'b1, 1'b0, 1'b0, 8'd0});
    else n_pass++;
    DataAdr = 32'd0;
    #1;
    n_checks++;
    if (ReadData !== 32'hA5A5_0001)
      $display("FAIL oor_word0_kept got=%h exp=%h", ReadData, 32'hA5A5_0001);
    else n_pass++;
    DataAdr = 32'd256;
    #1;
    n_checks++;
    if (ReadData !== 32'h0) $display("FAIL oor_read256 got=%h exp=0", ReadData);
    else n_pass++;
    do_reset();
    drive(1'b1, 32'd97, 32'h1234_5678);
    n_checks++;
    if ({done, pass, timeout, wr_count} !== exp_flags())
      $display("FAIL misal_status got=%h exp=%h", {done, pass, timeout, wr_count}, exp_flags());
    else n_pass++;
    DataAdr = 32'd96;
    #1;
    e = exp_read(32'd96, k);
    if (k) begin
      n_checks++;
      if (ReadData !== e) $display("FAIL misal_word_kept got=%h exp=%h", ReadData, e);
      else n_pass++;
    end
    DataAdr = 32'd97;
    #1;
    n_checks++;
    if (ReadData !== 32'h0) $display("FAIL misal_read97 got=%h exp=0", ReadData);
    else n_pass++;
  endtask

  task automatic test_watchdog();
`ifdef DMEM_WATCHDOG_EN
    do_reset();
    repeat (TMO - 1) drive(1'b0, 32'd0, 32'd0);
    n_checks++;
    if ({done, pass, timeout, wr_count} !== 11'h0)
      $display("FAIL wd_before got=%h exp=%h", {done, pass, timeout, wr_count}, 11'h0);
    else n_pass++;
    drive(1'b0, 32'd0, 32'd0);
    n_checks++;
    if ({done, pass, timeout, wr_count} !== {1'b1, 1'b0, 1'b1, 8'd0})
      $display("FAIL wd_expire got=%h exp=%h", {done, pass, timeout, wr_count}, {1'b1, 1'b0, 1'b1, 8'd0});
    else n_pass++;
    do_reset();
    repeat (TMO - 1) drive(1'b0, 32'd0, 32'd0);
    drive(1'b1, 32'd100, 32'd7);
    n_checks++;
    if ({done, pass, timeout, wr_count} !== {1'b1, 1'b1, 1'b0, 8'd1})
      $display("FAIL wd_priority got=%h exp=%h", {done, pass, timeout, wr_count}, {1'b1, 1'b1, 1'b0, 8'd1});
    else n_pass++;
`else
    do_reset();
    repeat (TMO + 10) drive(1'b0, 32'd0, 32'd0);
    n_checks++;
    if ({done, pass, timeout, wr_count} !== 11'h0)
      $display("FAIL nowd_idle got=%h exp=%h", {done, pass, timeout, wr_count}, 11'h0);
    else n_pass++;
`endif
  endtask

  task automatic test_async_reset();
    bit k;
    do_reset();
    drive(1'b1, 32'd96, 32'd5);
    drive(1'b1, 32'd100, 32'd7);
    n_checks++;
    if ({done, pass} !== 2'b11) $display("FAIL areset_pre got=%b exp=11", {done, pass});
    else n_pass++;
    #2;
    reset = 1'b0;
    m_st = M_RUN; m_cnt = 0; m_cyc = 0;
    #1;
    n_checks++;
    if ({done, pass, timeout, wr_count} !== exp_flags())
      $display("FAIL areset_flags got=%h exp=%h", {done, pass, timeout, wr_count}, exp_flags());
    else n_pass++;
    DataAdr = 32'd96;
    #1;
    n_checks++;
    if (ReadData !== 32'd5 || ReadData !== exp_read(32'd96, k))
      $display("FAIL areset_mem96 got=%h exp=%h", ReadData, 32'd5);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 260; i++) begin
      drive(1'b1, rand_word_adr(), $urandom);
      if (i == 253 || i == 254) begin
        n_checks++;
        if (wr_count !== 8'(m_cnt))
          $display("FAIL sat_edge i=%0d got=%0d exp=%0d", i, wr_count, m_cnt);
        else n_pass++;
      end
    end
    n_checks++;
    if (wr_count !== 8'd255) $display("FAIL sat_final got=%0d exp=255", wr_count);
    else n_pass++;
    n_checks++;
    if ({done, pass, timeout, wr_count} !== exp_flags())
      $display("FAIL sat_status got=%h exp=%h", {done, pass, timeout, wr_count}, exp_flags());
    else n_pass++;
  endtask

  task automatic test_random();
    bit k;
    logic [31:0] a, e;
    do_reset();
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) < 6) drive(1'b1, rand_word_adr(), $urandom);
      else drive(1'b0, 32'($urandom), 32'($urandom));
      a = 32'($urandom_range(0, 4 * DEPTH + 63));
      DataAdr = a;
      #1;
      e = exp_read(a, k);
      if (k) begin
        n_checks++;
        if (ReadData !== e) $display("FAIL rand_read adr=%0d got=%h exp=%h", a, ReadData, e);
        else n_pass++;
      end
      n_checks++;
      if ({done, pass, timeout, wr_count} !== exp_flags())
        $display("FAIL rand_status i=%0d got=%h exp=%h", i, {done, pass, timeout, wr_count}, exp_flags());
      else n_pass++;
    end
    drive(1'b1, 32'(PASS_ADR), 32'($urandom_range(6, 8)));
    n_checks++;
    if ({done, pass, timeout, wr_count} !== exp_flags())
      $display("FAIL rand_mailbox got=%h exp=%h", {done, pass, timeout, wr_count}, exp_flags());
    else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) m_val[i] = 1'b0;
    test_reset();
    test_pass();
    test_fail_value();
    test_out_of_range();
    test_watchdog();
    test_async_reset();
    test_saturate();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
